// File: rtl/scan_pkg.sv
// scan_pkg: shared state, index type and counter-width helper for the digit scanner
package scan_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;
  typedef logic [1:0] idx_t;
  function automatic int scan_cw(int dwell, int blank);
    int m;
    m = dwell > blank ? dwell : blank;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/scan_next_idx.sv
// scan_next_idx: cyclic search of the mask for the next digit; SCAN_DIR_EN adds a descending direction
import scan_pkg::*;
module scan_next_idx (
`ifdef SCAN_DIR_EN
  input  logic       dir,
`endif
  input  idx_t       idx,
  input  logic [3:0] mask,
  input  logic       incl_self,
  output idx_t       nxt,
  output logic       wrap
);
`ifndef SCAN_DIR_EN
  logic dir;
  assign dir = 1'b0;
`endif
  idx_t c;
  // walk offsets from far to near so the nearest hit is the one that sticks
  always_comb begin
    nxt = idx;
    wrap = 1'b0;
    c = idx;
    for (int k = 4; k >= 0; k--) begin
      c = dir ? idx - 2'(k) : idx + 2'(k);
      if ((incl_self ? k < 4 : k > 0) && mask[c]) begin
        nxt = c;
        wrap = dir ? k > int'(idx) : k + int'(idx) > 3;
      end
    end
  end
endmodule

// File: rtl/scan_seq_139.sv
// scan_seq_139: drives B/A/G_L of a 74x139 half to scan masked digits with dwell and blanking
// Optional: define SCAN_DIR_EN to add the DIR input (1 = descending scan order).
import scan_pkg::*;
module scan_seq_139 #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [3:0] MASK,
`ifdef SCAN_DIR_EN
  input  logic       DIR,
`endif
  output logic       A,
  output logic       B,
  output logic       G_L,
  output logic       STROBE,
  output logic       WRAP
);
  localparam int CW = scan_cw(DWELL, BLANK);
  localparam int BL = BLANK > 0 ? BLANK - 1 : 0;
  localparam state_t FIRST = BLANK > 0 ? S_BLANK : S_DWELL;
  state_t state, nstate;
  idx_t idx, nidx, sel;
  logic [CW-1:0] cnt, ncnt;
  logic run, last_b, last_d, go, wr;
  logic na, nb, ng, nstb, nwrap;
  scan_next_idx u_next (
`ifdef SCAN_DIR_EN
    .dir(DIR),
`endif
    .idx(idx),
    .mask(MASK),
    .incl_self(state == S_IDLE),
    .nxt(sel),
    .wrap(wr)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      A <= 1'b0;
      B <= 1'b0;
      G_L <= 1'b1;
      STROBE <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      cnt <= ncnt;
      A <= na;
      B <= nb;
      G_L <= ng;
      STROBE <= nstb;
      WRAP <= nwrap;
    end
  end
  always_comb begin
    run = EN && MASK != 4'b0;
    last_b = cnt == CW'(BL);
    last_d = cnt == CW'(DWELL - 1);
    go = state == S_IDLE || (state == S_DWELL && last_d);
    nstate = !run ? S_IDLE :
             state == S_IDLE ? FIRST :
             state == S_BLANK ? (last_b ? S_DWELL : S_BLANK) :
             last_d ? FIRST : S_DWELL;
    nidx = run && go ? sel : idx;
    ncnt = (!run || go || (state == S_BLANK && last_b)) ? '0 : cnt + 1'b1;
  end
  // outputs are computed for the coming cycle so the flops show its state and index
  always_comb begin
    na = nidx[0];
    nb = nidx[1];
    ng = nstate != S_DWELL;
    nstb = nstate == S_DWELL && (state != S_DWELL || last_d);
    nwrap = run && go && wr;
  end
endmodule

// File: tb/tb_scan_seq_139.sv
// tb_scan_seq_139: directed checks of the digit scanner (BLANK=1 and BLANK=0 instances)
module tb_scan_seq_139;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic EN = 1'b0;
  logic [3:0] MASK = 4'b0;
  logic A, B, G_L, STROBE, WRAP;
  logic A0, B0, G_L0, STROBE0, WRAP0;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  scan_seq_139 #(.DWELL(4), .BLANK(1)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MASK(MASK),
`ifdef SCAN_DIR_EN
    .DIR(1'b0),
`endif
    .A(A), .B(B), .G_L(G_L), .STROBE(STROBE), .WRAP(WRAP)
  );
  scan_seq_139 #(.DWELL(4), .BLANK(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MASK(MASK),
`ifdef SCAN_DIR_EN
    .DIR(1'b0),
`endif
    .A(A0), .B(B0), .G_L(G_L0), .STROBE(STROBE0), .WRAP(WRAP0)
  );
  task automatic do_reset(input logic [3:0] m);
    RESET = 1'b1;
    EN = 1'b0;
    MASK = 4'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    EN = 1'b1;
    MASK = m;
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    EN = 1'b1;
    MASK = 4'b1111;
    repeat (3) @(negedge CLK);
    checks++;
    if ({B, A, G_L, STROBE, WRAP} !== 5'b00100) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", {B, A, G_L, STROBE, WRAP}, 5'b00100);
    end
    checks++;
    if ({B0, A0, G_L0, STROBE0, WRAP0} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_b0 got=%b exp=%b", {B0, A0, G_L0, STROBE0, WRAP0}, 5'b00100);
    end
  endtask
  task automatic test_full_mask;
    int seq[0:4] = '{0, 1, 2, 3, 0};
    logic [1:0] d;
    logic [4:0] e;
    do_reset(4'b1111);
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK);
      d = 2'(seq[(c - 1) / 5]);
      e = {d, (c - 1) % 5 == 0, (c - 1) % 5 == 1, c == 21};
      checks++;
      if ({B, A, G_L, STROBE, WRAP} !== e) begin
        failures++;
        $display("FAIL full_mask c=%0d got=%b exp=%b", c, {B, A, G_L, STROBE, WRAP}, e);
      end
    end
  endtask
  task automatic test_mask_0101;
    int seq[0:4] = '{0, 2, 0, 2, 0};
    logic [1:0] d;
    logic [4:0] e;
    do_reset(4'b0101);
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK);
      d = 2'(seq[(c - 1) / 5]);
      e = {d, (c - 1) % 5 == 0, (c - 1) % 5 == 1, c == 11 || c == 21};
      checks++;
      if ({B, A, G_L, STROBE, WRAP} !== e) begin
        failures++;
        $display("FAIL mask_0101 c=%0d got=%b exp=%b", c, {B, A, G_L, STROBE, WRAP}, e);
      end
    end
  endtask
  task automatic test_single_digit;
    logic [4:0] e;
    do_reset(4'b1000);
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      e = {2'b11, (c - 1) % 5 == 0, (c - 1) % 5 == 1, c > 1 && (c - 1) % 5 == 0};
      checks++;
      if ({B, A, G_L, STROBE, WRAP} !== e) begin
        failures++;
        $display("FAIL single_digit c=%0d got=%b exp=%b", c, {B, A, G_L, STROBE, WRAP}, e);
      end
    end
  endtask
  task automatic test_blank0;
    int seq[0:4] = '{0, 1, 2, 3, 0};
    logic [1:0] d;
    logic [4:0] e;
    do_reset(4'b1111);
    for (int c = 1; c <= 17; c++) begin
      @(negedge CLK);
      d = 2'(seq[(c - 1) / 4]);
      e = {d, 1'b0, (c - 1) % 4 == 0, c == 17};
      checks++;
      if ({B0, A0, G_L0, STROBE0, WRAP0} !== e) begin
        failures++;
        $display("FAIL blank0 c=%0d got=%b exp=%b", c, {B0, A0, G_L0, STROBE0, WRAP0}, e);
      end
    end
  endtask
  task automatic test_en_drop;
    logic [4:0] ev[0:7] = '{5'b10100, 5'b10100, 5'b10100, 5'b10010,
                            5'b10000, 5'b10000, 5'b10000, 5'b11100};
    do_reset(4'b1111);
    repeat (14) @(negedge CLK);
    EN = 1'b0;
    for (int c = 15; c <= 22; c++) begin
      @(negedge CLK);
      if (c == 16) EN = 1'b1;
      checks++;
      if ({B, A, G_L, STROBE, WRAP} !== ev[c - 15]) begin
        failures++;
        $display("FAIL en_drop c=%0d got=%b exp=%b", c, {B, A, G_L, STROBE, WRAP}, ev[c - 15]);
      end
    end
  endtask
  task automatic test_reset_mid_and_zero_mask;
    do_reset(4'b1111);
    repeat (18) @(negedge CLK);
    checks++;
    if ({B, A, G_L} !== 5'b110) begin
      failures++;
      $display("FAIL mid_dwell_pre got=%b exp=%b", {B, A, G_L}, 3'b110);
    end
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if ({B, A, G_L, STROBE, WRAP} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=%b", {B, A, G_L, STROBE, WRAP}, 5'b00100);
    end
    RESET = 1'b0;
    EN = 1'b1;
    MASK = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      checks++;
      if ({B, A, G_L, STROBE, WRAP} !== 5'b00100) begin
        failures++;
        $display("FAIL zero_mask c=%0d got=%b exp=%b", c, {B, A, G_L, STROBE, WRAP}, 5'b00100);
      end
    end
  endtask
  initial begin
    test_reset;
    test_full_mask;
    test_mask_0101;
    test_single_digit;
    test_blank0;
    test_en_drop;
    test_reset_mid_and_zero_mask;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
